fifo_mrp: RTL and testbench

FIFO_MRP -- requirements
Module: fifo_mrp

---
 rtl/fifo_mrp.sv | 124 ++++++++++++
 tb/tb_fifo_mrp.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_mrp.sv
// fifo_mrp: single-writer FIFO with NUM_RP independent read ports.
// Every accepted write is seen by every active port; each port pops at
// its own pace. The slowest active port decides whether the writer may
// write. Read data is first-word fall-through.
module fifo_mrp #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int NUM_RP      = 2,
  parameter int AFULL_LEVEL = 2**ADDR_WIDTH - 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic                               w_en,
  input  logic [DATA_WIDTH-1:0]              data_in,
  input  logic [NUM_RP-1:0]                  port_en,
  input  logic [NUM_RP-1:0]                  r_en,
  output logic [NUM_RP*DATA_WIDTH-1:0]       data_out,
  output logic [NUM_RP-1:0]                  n_empty,
  output logic [NUM_RP*(ADDR_WIDTH+1)-1:0]   count,
  output logic                               n_full,
  output logic                               almost_full,
  output logic                               overflow,
  output logic [NUM_RP-1:0]                  underflow
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [PW-1:0] PTR_ZERO  = PW'(0);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] FULL_CNT  = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_CNT = PW'(AFULL_LEVEL);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]         w_ptr_r;
  logic [PW-1:0]         r_ptr_r [NUM_RP];
  logic                  overflow_r;
  logic [NUM_RP-1:0]     underflow_r;

  logic [PW-1:0]         cnt_s [NUM_RP];
  logic [NUM_RP-1:0]     n_empty_s;
  logic [NUM_RP-1:0]     pop_s;
  logic [NUM_RP-1:0]     full_vec_s;
  logic [NUM_RP-1:0]     afull_vec_s;
  logic                  n_full_s;
  logic                  wr_acc_s;
  logic [PW-1:0]         w_ptr_nxt_s;

  // Per-port occupancy and status from registered pointers; the extra
  // pointer bit makes the modular difference distinguish full from empty.
  always_comb begin
    n_empty_s   = {NUM_RP{1'b0}};
    pop_s       = {NUM_RP{1'b0}};
    full_vec_s  = {NUM_RP{1'b0}};
    afull_vec_s = {NUM_RP{1'b0}};
    for (int i = 0; i < NUM_RP; i++) begin
      cnt_s[i]       = w_ptr_r - r_ptr_r[i];
      n_empty_s[i]   = port_en[i] && (cnt_s[i] != PTR_ZERO);
      full_vec_s[i]  = port_en[i] && (cnt_s[i] == FULL_CNT);
      afull_vec_s[i] = port_en[i] && (cnt_s[i] >= AFULL_CNT);
      pop_s[i]       = r_en[i] && n_empty_s[i];
    end
    n_full_s = ~|full_vec_s;
    wr_acc_s = w_en && n_full_s;
    if (wr_acc_s) begin
      w_ptr_nxt_s = w_ptr_r + PTR_ONE;
    end else begin
      w_ptr_nxt_s = w_ptr_r;
    end
  end

  // Pointer and sticky-flag state; reset beats flush, flush beats traffic.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr_r     <= PTR_ZERO;
      overflow_r  <= 1'b0;
      underflow_r <= {NUM_RP{1'b0}};
      for (int i = 0; i < NUM_RP; i++) begin
        r_ptr_r[i] <= PTR_ZERO;
      end
    end else if (flush) begin
      w_ptr_r <= PTR_ZERO;
      for (int i = 0; i < NUM_RP; i++) begin
        r_ptr_r[i] <= PTR_ZERO;
      end
    end else begin
      w_ptr_r     <= w_ptr_nxt_s;
      overflow_r  <= overflow_r | (w_en & ~n_full_s);
      underflow_r <= underflow_r | (r_en & port_en & ~n_empty_s);
      for (int i = 0; i < NUM_RP; i++) begin
        // An idle port shadows the writer so it only sees data written after enabling.
        if (!port_en[i]) begin
          r_ptr_r[i] <= w_ptr_nxt_s;
        end else if (pop_s[i]) begin
          r_ptr_r[i] <= r_ptr_r[i] + PTR_ONE;
        end else begin
          r_ptr_r[i] <= r_ptr_r[i];
        end
      end
    end
  end

  // Storage write; contents are never cleared, pointers alone define validity.
  always_ff @(posedge clk) begin
    if (!reset && !flush && wr_acc_s) begin
      mem_r[w_ptr_r[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_RP; g++) begin : g_port
      assign data_out[g*DATA_WIDTH +: DATA_WIDTH] = mem_r[r_ptr_r[g][ADDR_WIDTH-1:0]];
      assign count[g*PW +: PW]                    = cnt_s[g];
    end
  endgenerate

  assign n_empty     = n_empty_s;
  assign n_full      = n_full_s;
  assign almost_full = |afull_vec_s;
  assign overflow    = overflow_r;
  assign underflow   = underflow_r;

endmodule

// File: tb/tb_fifo_mrp.sv
// Self-checking bench for fifo_mrp: a per-port queue model is checked
// against the DUT on every falling edge, plus hand-computed literals.
module tb_fifo_mrp;

  localparam int DW = 16;
  localparam int AW = 2;
  localparam int NP = 2;
  localparam int PW = AW + 1;
  localparam int DEPTH = 4;
  localparam int AFL = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              w_en = 1'b0;
  logic [DW-1:0]     data_in = 16'h0000;
  logic [NP-1:0]     port_en = 2'b11;
  logic [NP-1:0]     r_en = 2'b00;
  logic [NP*DW-1:0]  data_out;
  logic [NP-1:0]     n_empty;
  logic [NP*PW-1:0]  count;
  logic              n_full;
  logic              almost_full;
  logic              overflow;
  logic [NP-1:0]     underflow;

  fifo_mrp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RP(NP), .AFULL_LEVEL(AFL)) dut (
    .clk(clk), .reset(reset), .flush(flush), .w_en(w_en), .data_in(data_in),
    .port_en(port_en), .r_en(r_en), .data_out(data_out), .n_empty(n_empty),
    .count(count), .n_full(n_full), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  // Model: each port holds the queue of words it has yet to pop.
  logic [DW-1:0] mq [NP][$];
  logic          m_ovf = 1'b0;
  logic [NP-1:0] m_udf = 2'b00;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_update();
    bit full;
    bit wacc;
    bit [NP-1:0] pop;
    if (reset) begin
      for (int i = 0; i < NP; i++) mq[i].delete();
      m_ovf = 1'b0;
      m_udf = 2'b00;
    end else if (flush) begin
      for (int i = 0; i < NP; i++) mq[i].delete();
    end else begin
      full = 1'b0;
      for (int i = 0; i < NP; i++)
        if (port_en[i] && mq[i].size() == DEPTH) full = 1'b1;
      wacc = w_en && !full;
      if (w_en && full) m_ovf = 1'b1;
      for (int i = 0; i < NP; i++) begin
        pop[i] = port_en[i] && r_en[i] && mq[i].size() > 0;
        if (port_en[i] && r_en[i] && mq[i].size() == 0) m_udf[i] = 1'b1;
      end
      for (int i = 0; i < NP; i++) begin
        if (!port_en[i]) begin
          mq[i].delete();
        end else begin
          if (pop[i]) void'(mq[i].pop_front());
          if (wacc) mq[i].push_back(data_in);
        end
      end
    end
  endtask

  // One clock: apply inputs, advance the model at the edge, return to idle.
  task automatic step(input logic we, input logic [DW-1:0] d, input logic [NP-1:0] re);
    w_en = we;
    data_in = d;
    r_en = re;
    @(posedge clk);
    model_update();
    #1;
    w_en = 1'b0;
    r_en = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 16'h0000, 2'b00);
    reset = 1'b0;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      bit m_nf;
      bit m_af;
      m_nf = 1'b1;
      m_af = 1'b0;
      for (int i = 0; i < NP; i++) begin
        int sz;
        sz = mq[i].size();
        if (port_en[i] && sz == DEPTH) m_nf = 1'b0;
        if (port_en[i] && sz >= AFL) m_af = 1'b1;
        chk($sformatf("cyc_count%0d", i), 32'(count[i*PW +: PW]), 32'(sz));
        chk($sformatf("cyc_n_empty%0d", i), 32'(n_empty[i]), 32'(port_en[i] && sz > 0));
        if (port_en[i] && sz > 0)
          chk($sformatf("cyc_data%0d", i), 32'(data_out[i*DW +: DW]), 32'(mq[i][0]));
      end
      chk("cyc_n_full", 32'(n_full), 32'(m_nf));
      chk("cyc_almost_full", 32'(almost_full), 32'(m_af));
      chk("cyc_overflow", 32'(overflow), 32'(m_ovf));
      chk("cyc_underflow", 32'(underflow), 32'(m_udf));
    end
  end

  initial begin
    // Reset state
    do_reset();
    do_reset();
    chk_on = 1'b1;
    chk("rst_n_full", 32'(n_full), 32'd1);
    chk("rst_n_empty", 32'(n_empty), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_flags", {30'd0, overflow, |underflow}, 32'd0);

    // Broadcast
    step(1'b1, 16'h00A1, 2'b00);
    step(1'b1, 16'h00A2, 2'b00);
    chk("bc_d0_first", 32'(data_out[15:0]), 32'h00A1);
    step(1'b0, 16'h0000, 2'b01);
    chk("bc_d0_second", 32'(data_out[15:0]), 32'h00A2);
    step(1'b0, 16'h0000, 2'b01);
    chk("bc_count0", 32'(count[2:0]), 32'd0);
    chk("bc_n_empty", 32'(n_empty), 32'h2);
    chk("bc_count1", 32'(count[5:3]), 32'd2);
    chk("bc_d1", 32'(data_out[31:16]), 32'h00A1);

    // Slow port holds the FIFO full
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 16'(16'h00C0 + k), 2'b00);
    for (int k = 0; k < 4; k++) step(1'b0, 16'h0000, 2'b01);
    chk("sf_n_full", 32'(n_full), 32'd0);
    chk("sf_afull", 32'(almost_full), 32'd1);
    step(1'b1, 16'h00C4, 2'b00);
    chk("sf_overflow", 32'(overflow), 32'd1);
    chk("sf_count1_held", 32'(count[5:3]), 32'd4);
    chk("sf_count0_held", 32'(count[2:0]), 32'd0);
    step(1'b0, 16'h0000, 2'b10);
    chk("sf_n_full_after_pop", 32'(n_full), 32'd1);
    chk("sf_d1_after_pop", 32'(data_out[31:16]), 32'h00C1);

    // Inactive port never blocks writes and sees only later data
    do_reset();
    port_en = 2'b01;
    for (int k = 0; k < 4; k++) step(1'b1, 16'(16'h00D0 + k), 2'b00);
    chk("ia_n_full", 32'(n_full), 32'd0);
    step(1'b0, 16'h0000, 2'b10);
    chk("ia_no_udf", 32'(underflow), 32'd0);
    port_en = 2'b11;
    #1;
    chk("ia_n_empty1", 32'(n_empty[1]), 32'd0);
    chk("ia_count1", 32'(count[5:3]), 32'd0);
    step(1'b0, 16'h0000, 2'b01);
    step(1'b1, 16'h00B0, 2'b00);
    chk("ia_d1", 32'(data_out[31:16]), 32'h00B0);
    chk("ia_count1_one", 32'(count[5:3]), 32'd1);

    // Same-cycle write and pop decided on registered state
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 16'(16'h00E0 + k), 2'b00);
    step(1'b1, 16'h00EE, 2'b01);
    chk("sim_overflow", 32'(overflow), 32'd1);
    chk("sim_count0", 32'(count[2:0]), 32'd3);
    chk("sim_count1", 32'(count[5:3]), 32'd4);
    for (int k = 0; k < 3; k++) step(1'b0, 16'h0000, 2'b11);
    step(1'b1, 16'h00EF, 2'b01);
    chk("sim_underflow", 32'(underflow), 32'd1);
    chk("sim_count0_one", 32'(count[2:0]), 32'd1);
    chk("sim_d0", 32'(data_out[15:0]), 32'h00EF);

    // Pointer wrap
    do_reset();
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 16'(16'h0100 + k), 2'b00);
      chk("wr_d0", 32'(data_out[15:0]), 32'(16'h0100 + k));
      chk("wr_d1", 32'(data_out[31:16]), 32'(16'h0100 + k));
      if (count[2:0] > 3'd1 || count[5:3] > 3'd1)
        chk("wr_count_le1", {26'd0, count}, 32'h9);
      step(1'b0, 16'h0000, 2'b11);
    end
    chk("wr_n_empty_end", 32'(n_empty), 32'd0);

    // Flush keeps sticky flags; reset clears everything
    do_reset();
    step(1'b0, 16'h0000, 2'b01);
    for (int k = 0; k < 5; k++) step(1'b1, 16'(16'h0200 + k), 2'b00);
    step(1'b0, 16'h0000, 2'b11);
    chk("fl_pre_count0", 32'(count[2:0]), 32'd3);
    flush = 1'b1;
    step(1'b1, 16'h02FF, 2'b00);
    flush = 1'b0;
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_overflow", 32'(overflow), 32'd1);
    chk("fl_underflow", 32'(underflow), 32'd1);
    step(1'b1, 16'h0300, 2'b00);
    step(1'b1, 16'h0301, 2'b00);
    chk("fl_refill_d0", 32'(data_out[15:0]), 32'h0300);
    do_reset();
    chk("fr_flags", {30'd0, overflow, |underflow}, 32'd0);
    chk("fr_n_full", 32'(n_full), 32'd1);
    chk("fr_count", 32'(count), 32'd0);

    step(1'b0, 16'h0000, 2'b00);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
